display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Scheduler that time-multiplexes four BCD/hex digits onto the 74HC595 shift driver (WIDTH=16) through its start/busy handshake.
- Owns digit sequencing, frame snapshotting, per-digit dwell timing, PWM-style brightness (blank frames), leading-zero blanking and enable/shutdown.
- Sits between the sensor value formatter (d0..d3) and shift_74hc595; it replaces free-running scan counters.

Parameters:
- SLICE_CYC, 2500, clk cycles per brightness slice; dwell per digit = 8*SLICE_CYC.
- SEG_ACTIVE_LOW, 1, 1 = segment bits driven low-on; 0 = high-on.
- SEL_ACTIVE_LOW, 0, 1 = digit-select bits low-active; 0 = high-active.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable.
- d0,d1,d2,d3  in  4 each  hex digits; d0 = least significant, d3 = most significant.
- dp_mask  in  4  decimal point per digit (bit i -> digit i).
- lz_en  in  1  leading-zero blanking enable.
- bright  in  3  brightness 0..7; lit slices = bright+1.
- busy  in  1  shifter busy.
- start  out  1  one-cycle transfer request to shifter.
- data16  out  16  {seg[7:0], sel[7:0]}; seg[7]=dp, seg[6:0]=g..a; sel[3:0] one-hot digit, sel[7:4] inactive.
- frame_done  out  1  one-cycle pulse after digit 3 dwell ends.
- active  out  1  high from leaving IDLE until the shutdown blank frame completes.

Behaviour:
- Reset values: start=0, frame_done=0, active=0, data16 = blank word (seg all off, sel all inactive per polarity params); FSM=IDLE, digit index=0.
- FSM states: IDLE -> SNAP -> SEND -> WAITB -> DWELL -> (BLANK_SEND -> BLANK_WAITB -> DWELL) -> NEXT -> SEND ... ; plus OFF_SEND -> OFF_WAITB -> IDLE.
- IDLE: leave on en=1 and busy=0, going to SNAP.
- SNAP: latch d0..d3, dp_mask, lz_en, bright in one cycle. Snapshots are taken only at digit index 0, so a frame never tears.
- SEND: data16 = encoded digit word. start=1 for exactly one cycle, only when busy=0; otherwise hold in SEND.
- WAITB: ignore busy on the first cycle after start; then wait for busy=0.
- DWELL counter starts at 0 on the cycle busy is seen low.
- DWELL: at count = (bright+1)*SLICE_CYC with bright<7, go to BLANK_SEND. The blank word is shifted; the dwell counter keeps running throughout.
- DWELL expiry: dwell ends at count = 8*SLICE_CYC-1. NEXT is entered only when the counter has expired and busy=0.
- NEXT: index increments mod 4.
  - Wrap 3->0 pulses frame_done.
  - Then go to SNAP if en=1, else OFF_SEND.
- en falling mid-operation:
  - Any in-progress transfer completes.
  - The current dwell is abandoned at the next DWELL or NEXT decision.
  - Then OFF_SEND shifts the blank word and returns to IDLE.
  - active drops the cycle the FSM enters IDLE.
- Encoding:
  - hex 0-F uses the standard 7-seg patterns. Digit i with dp_mask[i] sets the dp segment on.
  - Polarity inversion is applied last.
- Leading-zero blanking (lz_en=1): d3 blanked if 0; d2 blanked if 0 and d3 blanked; d1 likewise. d0 is never blanked.
  - A blanked digit still occupies its time slot.
  - A blanked digit sends seg all-off with its sel bit active.
- rst asserted in any state: all outputs return to reset values next edge.
  - start deasserts immediately.
  - No blank frame is sent; the shifter shares rst.
- Counter width: clog2(8*SLICE_CYC). No wrap is possible because the counter is cleared on every DWELL entry from WAITB.

Decomposition:
- Shared package disp_pkg holds:
  - state enum;
  - 16-entry 7-seg pattern constant table;
  - BLANK_SEG/BLANK_SEL constants;
  - data16 field offsets (SEG_LSB=8, SEL_LSB=0).
- One sub-module scan_dwell_timer (counter + slice/expiry compares; inputs clr, bright; outputs dim_hit, dwell_done).
- Encoding stays inline.

Test Plan:
- Reset with en=1, d=4'h1,2,3,4, bright=7, stub shifter (busy 1600 cycles, asserted 1 cycle after start), SLICE_CYC=20 -> start pulses in digit order 0,1,2,3. data16 = 16'hF901, 16'hA402, 16'hB008, 16'h9908 is wrong; must be 16'hF901, 16'hA402, 16'hB004, 16'h9908. frame_done after 4th dwell.
- bright=2, SLICE_CYC=20 -> a blank-word start (16'hFF00) occurs at 60 cycles into each dwell. The next digit start does not occur before 160 cycles after the previous busy fall.
- lz_en=1, d3..d0=0,0,7,0 -> d3 and d2 slots send seg 8'hFF with sel 8'h08 and 8'h04. d1 sends 8'hF8. d0 sends 8'hC0.
- d changed mid-frame (at digit 1) -> remaining digits of that frame show the old values; new values appear from the next digit 0.
- en dropped during WAITB of digit 2 -> the transfer finishes, then one 16'hFF00 transfer, then IDLE. active=0 and no further starts.
- rst pulsed while busy=1 in WAITB -> next cycle start=0, data16=16'hFF00, active=0; restart begins at digit 0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared state encoding, segment patterns and word layout for the display scanner.
package disp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SNAP,
    S_SEND,
    S_WAITB,
    S_DWELL,
    S_BLANK_SEND,
    S_BLANK_WAITB,
    S_NEXT,
    S_OFF_SEND,
    S_OFF_WAITB
  } scan_state_t;

  // Active-high g..a patterns indexed by hex value (entry 15 first)
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] BLANK_SEG = 8'h00;
  localparam logic [7:0] BLANK_SEL = 8'h00;

  localparam int SEG_LSB = 8;
  localparam int SEL_LSB = 0;

endpackage

// File: rtl/scan_dwell_timer.sv
// Per-digit dwell counter: brightness-slice compare and dwell expiry.
module scan_dwell_timer #(
  parameter int SLICE_CYC = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [2:0] bright,
  output logic       dim_hit,
  output logic       dwell_done
);

  localparam int CW = $clog2(8 * SLICE_CYC);
  localparam logic [CW-1:0] DWELL_LAST = CW'(8 * SLICE_CYC - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] dim_at;

  assign dim_at     = CW'((int'(bright) + 1) * SLICE_CYC);
  assign dim_hit    = (bright != 3'd7) && (cnt == dim_at);
  assign dwell_done = (cnt == DWELL_LAST);

  // Holds at expiry so a long shifter stall cannot wrap back into a slice compare
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!dwell_done) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scheduler driving a 74HC595 shifter over start/busy.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SLICE_CYC      = 2500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  d0,
  input  logic [3:0]  d1,
  input  logic [3:0]  d2,
  input  logic [3:0]  d3,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  input  logic [2:0]  bright,
  input  logic        busy,
  output logic        start,
  output logic [15:0] data16,
  output logic        frame_done,
  output logic        active
);

  function automatic logic [15:0] make_word(input logic [7:0] seg_ah, input logic [7:0] sel_ah);
    logic [15:0] w;
    w = '0;
    w[SEG_LSB +: 8] = (SEG_ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
    w[SEL_LSB +: 8] = (SEL_ACTIVE_LOW != 0) ? ~sel_ah : sel_ah;
    return w;
  endfunction

  scan_state_t     state;
  logic [1:0]      idx;
  logic [3:0][3:0] snap_d;
  logic [3:0]      snap_dp;
  logic            snap_lz;
  logic [2:0]      snap_bright;
  logic            blank3, blank2, blank1;
  logic [3:0]      lz_blank;
  logic [7:0]      seg_ah, sel_ah;
  logic [15:0]     digit_word, blank_word;
  logic            dim_hit, dwell_done;

  // Frame snapshot: SNAP is only visited at digit 0, so a frame never mixes values
  always_ff @(posedge clk) begin
    if (state == S_SNAP) begin
      snap_d      <= {d3, d2, d1, d0};
      snap_dp     <= dp_mask;
      snap_lz     <= lz_en;
      snap_bright <= bright;
    end
  end

  assign blank3   = snap_lz && (snap_d[3] == 4'h0);
  assign blank2   = blank3 && (snap_d[2] == 4'h0);
  assign blank1   = blank2 && (snap_d[1] == 4'h0);
  assign lz_blank = {blank3, blank2, blank1, 1'b0};

  always_comb begin
    seg_ah = BLANK_SEG;
    if (!lz_blank[idx]) begin
      seg_ah = {snap_dp[idx], SEG_TABLE[snap_d[idx]]};
    end
    sel_ah      = BLANK_SEL;
    sel_ah[idx] = 1'b1;
  end

  assign digit_word = make_word(seg_ah, sel_ah);
  assign blank_word = make_word(BLANK_SEG, BLANK_SEL);

  scan_dwell_timer #(
    .SLICE_CYC(SLICE_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == S_WAITB),
    .bright    (snap_bright),
    .dim_hit   (dim_hit),
    .dwell_done(dwell_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      start      <= 1'b0;
      frame_done <= 1'b0;
      active     <= 1'b0;
      data16     <= blank_word;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && !busy) begin
            active <= 1'b1;
            state  <= S_SNAP;
          end
        end
        S_SNAP: state <= S_SEND;
        S_SEND: begin
          if (!busy) begin
            data16 <= digit_word;
            start  <= 1'b1;
            state  <= S_WAITB;
          end
        end
        // start is still high on the first wait cycle, masking the shifter's busy latency
        S_WAITB: if (!start && !busy) state <= S_DWELL;
        S_DWELL: begin
          if (!en) begin
            state <= S_OFF_SEND;
          end else if (dwell_done && !busy) begin
            state <= S_NEXT;
          end else if (dim_hit) begin
            state <= S_BLANK_SEND;
          end
        end
        S_BLANK_SEND: begin
          if (!busy) begin
            data16 <= blank_word;
            start  <= 1'b1;
            state  <= S_BLANK_WAITB;
          end
        end
        S_BLANK_WAITB: if (!start && !busy) state <= S_DWELL;
        S_NEXT: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) frame_done <= 1'b1;
          if (!en) begin
            state <= S_OFF_SEND;
          end else if (idx == 2'd3) begin
            state <= S_SNAP;
          end else begin
            state <= S_SEND;
          end
        end
        S_OFF_SEND: begin
          if (!busy) begin
            data16 <= blank_word;
            start  <= 1'b1;
            idx    <= 2'd0;
            state  <= S_OFF_WAITB;
          end
        end
        S_OFF_WAITB: begin
          if (!start && !busy) begin
            active <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a 74HC595 busy stub and start-word scoreboard.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, lz_en, busy;
  logic [3:0]  d0, d1, d2, d3, dp_mask;
  logic [2:0]  bright;
  logic        start, frame_done, active;
  logic [15:0] data16;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_len = 16;
  int bcnt     = 0;
  logic prev_busy = 1'b0;

  logic [15:0] exp_q[$];
  logic [15:0] got_w[$];
  int          got_c[$];
  int          falls[$];
  int          fd[$];

  display_scan_ctrl #(
    .SLICE_CYC     (20),
    .SEG_ACTIVE_LOW(1),
    .SEL_ACTIVE_LOW(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .dp_mask   (dp_mask),
    .lz_en     (lz_en),
    .bright    (bright),
    .busy      (busy),
    .start     (start),
    .data16    (data16),
    .frame_done(frame_done),
    .active    (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shifter stub: busy rises on the edge that samples start, lasts busy_len cycles
  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      bcnt <= 0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      bcnt <= busy_len - 1;
    end else if (busy) begin
      if (bcnt == 0) busy <= 1'b0;
      else bcnt <= bcnt - 1;
    end
  end

  always @(negedge clk) begin
    if (start === 1'b1) begin
      got_w.push_back(data16);
      got_c.push_back(cyc);
    end
    if (prev_busy === 1'b1 && busy === 1'b0) falls.push_back(cyc);
    prev_busy = busy;
    if (frame_done === 1'b1) fd.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    got_w.delete();
    got_c.delete();
    falls.delete();
    fd.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int limit, input string tag);
    int k;
    k = 0;
    while (got_w.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_starts_seen"}, 32'(got_w.size() >= n), 32'd1);
  endtask

  task automatic check_words(input string tag);
    int i;
    logic [15:0] e;
    logic [31:0] o;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (i < got_w.size()) ? 32'(got_w[i]) : 32'hxxxxxxxx;
      check($sformatf("%s[%0d]", tag, i), o, 32'(e));
      i++;
    end
  endtask

  task automatic set_digits(input logic [3:0] a3, input logic [3:0] a2,
                            input logic [3:0] a1, input logic [3:0] a0);
    d3 = a3;
    d2 = a2;
    d1 = a1;
    d0 = a0;
  endtask

  initial begin
    int k;
    int dly;
    rst = 1'b1; en = 1'b0; lz_en = 1'b0; dp_mask = 4'h0; bright = 3'd7;
    set_digits(4'h0, 4'h0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);

    check("rst_start", 32'(start), 32'd0);
    check("rst_data16", 32'(data16), 32'hFF00);
    check("rst_active", 32'(active), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // Basic frame with a slow shifter
    busy_len = 1600; en = 1'b1; bright = 3'd7;
    set_digits(4'h4, 4'h3, 4'h2, 4'h1);
    exp_q.push_back(16'hF901); exp_q.push_back(16'hA402);
    exp_q.push_back(16'hB004); exp_q.push_back(16'h9908);
    do_reset();
    wait_starts(4, 10000, "t1");
    check("t1_active", 32'(active), 32'd1);
    k = 0;
    while (fd.size() < 1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("t1_fd_seen", 32'(fd.size() >= 1), 32'd1);
    check_words("t1_word");
    dly = (fd.size() > 0 && falls.size() > 3) ? fd[0] - falls[3] : -1;
    check("t1_fd_after_dwell", 32'(dly >= 160 && dly <= 170), 32'd1);
    repeat (3) @(negedge clk);
    check("t1_fd_single", 32'(fd.size()), 32'd1);

    // Dimmed frame: blank word mid-dwell, full dwell preserved
    busy_len = 16; bright = 3'd2;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i == 0) ? 16'hF901 : (i == 1) ? 16'hA402 : (i == 2) ? 16'hB004 : 16'h9908);
      exp_q.push_back(16'hFF00);
    end
    do_reset();
    wait_starts(8, 2000, "t2");
    check_words("t2_word");
    for (int i = 0; i < 4; i++) begin
      dly = (falls.size() > 2 * i && got_c.size() > 2 * i + 1) ? got_c[2 * i + 1] - falls[2 * i] : -1;
      check($sformatf("t2_blank_delay[%0d]=%0d", i, dly), 32'(dly >= 60 && dly <= 66), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      dly = (falls.size() > 2 * i && got_c.size() > 2 * i + 2) ? got_c[2 * i + 2] - falls[2 * i] : -1;
      check($sformatf("t2_next_delay[%0d]=%0d", i, dly), 32'(dly >= 160 && dly <= 170), 32'd1);
    end

    // Leading-zero blanking
    bright = 3'd7; lz_en = 1'b1;
    set_digits(4'h0, 4'h0, 4'h7, 4'h0);
    exp_q.push_back(16'hC001); exp_q.push_back(16'hF802);
    exp_q.push_back(16'hFF04); exp_q.push_back(16'hFF08);
    do_reset();
    wait_starts(4, 1500, "t3");
    check_words("t3_word");

    // Inputs change mid-frame; decimal point on digit 1
    lz_en = 1'b0; dp_mask = 4'b0010;
    set_digits(4'h4, 4'h3, 4'h2, 4'h1);
    exp_q.push_back(16'hF901); exp_q.push_back(16'h2402);
    exp_q.push_back(16'hB004); exp_q.push_back(16'h9908);
    exp_q.push_back(16'h9201); exp_q.push_back(16'h0202);
    exp_q.push_back(16'hF804); exp_q.push_back(16'h8008);
    do_reset();
    wait_starts(2, 800, "t4a");
    set_digits(4'h8, 4'h7, 4'h6, 4'h5);
    wait_starts(8, 2000, "t4b");
    check_words("t4_word");

    // Enable drops while digit 2 is being shifted
    dp_mask = 4'h0; busy_len = 100;
    set_digits(4'h4, 4'h3, 4'h2, 4'h1);
    exp_q.push_back(16'hF901); exp_q.push_back(16'hA402);
    exp_q.push_back(16'hB004); exp_q.push_back(16'hFF00);
    do_reset();
    wait_starts(3, 1500, "t5a");
    en = 1'b0;
    wait_starts(4, 600, "t5b");
    k = 0;
    while (active !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("t5_active_low", 32'(active), 32'd0);
    check("t5_off_done_first", 32'(falls.size()), 32'd4);
    dly = (got_c.size() > 3 && falls.size() > 2) ? got_c[3] - falls[2] : -1;
    check("t5_digit2_completed", 32'(dly > 0), 32'd1);
    repeat (300) @(negedge clk);
    check("t5_no_more_starts", 32'(got_w.size()), 32'd4);
    check("t5_still_idle", 32'(active), 32'd0);
    check("t5_no_frame_done", 32'(fd.size()), 32'd0);
    check_words("t5_word");

    // Reset while the shifter is busy
    en = 1'b1;
    do_reset();
    wait_starts(2, 800, "t6a");
    repeat (5) @(negedge clk);
    check("t6_pre_data16", 32'(data16), 32'hA402);
    check("t6_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_start", 32'(start), 32'd0);
    check("t6_rst_data16", 32'(data16), 32'hFF00);
    check("t6_rst_active", 32'(active), 32'd0);
    check("t6_rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clear_logs();
    rst = 1'b0;
    exp_q.push_back(16'hF901);
    wait_starts(1, 100, "t6b");
    check_words("t6_word");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
